// File: rtl/tensor_pkg.sv
// Shared types for the tensor-core feed path: accumulator width, tile payload, collect FSM states.
package tensor_pkg;

  localparam int unsigned ACC_W = 32;

  typedef struct packed {
    logic signed [ACC_W-1:0] c11;
    logic signed [ACC_W-1:0] c12;
    logic signed [ACC_W-1:0] c21;
    logic signed [ACC_W-1:0] c22;
  } tile_t;

  typedef enum logic [1:0] {
    WAIT11   = 2'd0,
    WAITEDGE = 2'd1,
    WAIT22   = 2'd2
  } collect_state_t;

endpackage

// File: rtl/tile_result_drain_if.sv
// Result word stream toward the bus-side writer (ready/valid, last marks the c22 word).
interface tile_result_drain_if #(
  parameter int unsigned ACC_W = tensor_pkg::ACC_W
) ();

  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);

endinterface

// File: rtl/tile_fifo.sv
// Synchronous FIFO of whole tiles; pointers carry an extra wrap bit to tell full from empty.
module tile_fifo
  import tensor_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  tile_t wr_data,
  input  logic  rd_en,
  output tile_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tile_t       mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tile_result_drain.sv
// Collects 2x2 accumulator tiles on the sequencer push pulses, queues them whole,
// and drains them as a c11,c12,c21,c22 word stream.
module tile_result_drain #(
  parameter int unsigned TILE_DEPTH = 4,
  parameter int unsigned ACC_W      = tensor_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    push11,
  input  logic                    pushedge,
  input  logic                    push22,
  input  logic                    seq_done,
  input  logic signed [ACC_W-1:0] c11,
  input  logic signed [ACC_W-1:0] c12,
  input  logic signed [ACC_W-1:0] c21,
  input  logic signed [ACC_W-1:0] c22,
  tile_result_drain_if.master     drain,
  output logic [31:0]             tile_count,
  output logic                    overflow_err,
  output logic                    seq_err,
  output logic                    all_done
);

  import tensor_pkg::*;

  collect_state_t state_q, state_d;
  logic lat11, latedge, commit, seq_err_set;
  logic signed [ACC_W-1:0] c11_q, c12_q, c21_q;

  logic  fifo_full, fifo_empty, wr_en, pop, handshake;
  tile_t wr_tile, head;
  logic [1:0] idx_q;
  logic done_pending;
  logic multi_push;

  assign multi_push = (push11 & pushedge) | (push11 & push22) | (pushedge & push22);

  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT11;
    else       state_q <= state_d;
  end

  // A stray push11 restarts the tile; any other unexpected push abandons it.
  always_comb begin
    state_d     = state_q;
    lat11       = 1'b0;
    latedge     = 1'b0;
    commit      = 1'b0;
    seq_err_set = 1'b0;
    if (start) begin
      state_d = WAIT11;
    end else if (multi_push) begin
      seq_err_set = 1'b1;
      state_d     = WAIT11;
    end else if (push11) begin
      lat11       = 1'b1;
      seq_err_set = (state_q != WAIT11);
      state_d     = WAITEDGE;
    end else if (pushedge) begin
      if (state_q == WAITEDGE) begin
        latedge = 1'b1;
        state_d = WAIT22;
      end else begin
        seq_err_set = 1'b1;
        state_d     = WAIT11;
      end
    end else if (push22) begin
      if (state_q == WAIT22) begin
        commit = 1'b1;
      end else begin
        seq_err_set = 1'b1;
      end
      state_d = WAIT11;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c11_q <= '0;
      c12_q <= '0;
      c21_q <= '0;
    end else begin
      if (lat11) c11_q <= c11;
      if (latedge) begin
        c12_q <= c12;
        c21_q <= c21;
      end
    end
  end

  always_comb begin
    wr_tile     = '0;
    wr_tile.c11 = c11_q;
    wr_tile.c12 = c12_q;
    wr_tile.c21 = c21_q;
    wr_tile.c22 = c22;
  end

  // A pop in the same cycle frees a slot, so a full FIFO still takes the commit.
  assign handshake = !fifo_empty && drain.out_ready;
  assign pop       = handshake && (idx_q == 2'd3);
  assign wr_en     = commit && (!fifo_full || pop);

  tile_fifo #(.DEPTH(TILE_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_tile),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)          idx_q <= '0;
    else if (handshake) idx_q <= idx_q + 2'd1;
  end

  always_comb begin
    drain.out_data  = '0;
    drain.out_valid = !fifo_empty;
    drain.out_last  = !fifo_empty && (idx_q == 2'd3);
    if (!fifo_empty) begin
      case (idx_q)
        2'd0:    drain.out_data = ACC_W'(head.c11);
        2'd1:    drain.out_data = ACC_W'(head.c12);
        2'd2:    drain.out_data = ACC_W'(head.c21);
        default: drain.out_data = ACC_W'(head.c22);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      tile_count   <= '0;
      overflow_err <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      if (wr_en)                tile_count   <= tile_count + 32'd1;
      if (commit && !wr_en)     overflow_err <= 1'b1;
      if (seq_err_set)          seq_err      <= 1'b1;
    end
  end

  // Completion is reported only once the collector is idle and the queue has drained.
  assign all_done = done_pending && fifo_empty && (state_q == WAIT11);

  always_ff @(posedge clk) begin
    if (reset || start) done_pending <= 1'b0;
    else if (seq_done)  done_pending <= 1'b1;
    else if (all_done)  done_pending <= 1'b0;
  end

endmodule

// File: tb/tb_tile_result_drain.sv
// Directed bench for tile_result_drain: stimulus queues expected words, a negedge monitor checks them.
module tb_tile_result_drain;

  logic clk = 1'b0;
  logic reset, start, push11, pushedge, push22, seq_done;
  logic signed [31:0] c11, c12, c21, c22;
  logic [31:0] tile_count;
  logic overflow_err, seq_err, all_done;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  tile_result_drain_if #(.ACC_W(32)) drain_if ();

  tile_result_drain #(.TILE_DEPTH(4), .ACC_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .push11       (push11),
    .pushedge     (pushedge),
    .push22       (push22),
    .seq_done     (seq_done),
    .c11          (c11),
    .c12          (c12),
    .c21          (c21),
    .c22          (c22),
    .drain        (drain_if.master),
    .tile_count   (tile_count),
    .overflow_err (overflow_err),
    .seq_err      (seq_err),
    .all_done     (all_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Issues push11, pushedge, push22 on three consecutive cycles starting in the current one.
  task automatic push_tile(input int a, input int b, input int c, input int d, input bit accept);
    if (accept) begin
      exp_q.push_back({1'b0, 32'(a)});
      exp_q.push_back({1'b0, 32'(b)});
      exp_q.push_back({1'b0, 32'(c)});
      exp_q.push_back({1'b1, 32'(d)});
    end
    push11 = 1'b1; c11 = 32'(a);
    tick();
    push11 = 1'b0; pushedge = 1'b1; c12 = 32'(b); c21 = 32'(c);
    tick();
    pushedge = 1'b0; push22 = 1'b1; c22 = 32'(d);
    tick();
    push22 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain_all(input bit toggle, input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !drain_if.out_valid) begin
        done = 1'b1;
        break;
      end
      drain_if.out_ready = toggle ? ((i % 2) == 0) : 1'b1;
      tick();
    end
    drain_if.out_ready = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: %0d words still expected, out_valid=%0b", exp_q.size(), drain_if.out_valid);
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (prev_stall && drain_if.out_valid) begin
      tests++;
      if (drain_if.out_data !== prev_data) begin
        fails++;
        $display("FAIL stall_stable: got %0d, expected %0d", drain_if.out_data, prev_data);
      end
    end
    if (drain_if.out_valid && drain_if.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got data %0d last %0b, expected no word",
                 $signed(drain_if.out_data), drain_if.out_last);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({drain_if.out_last, drain_if.out_data} !== e) begin
          fails++;
          $display("FAIL word: got data %0d last %0b, expected data %0d last %0b",
                   $signed(drain_if.out_data), drain_if.out_last, $signed(e[31:0]), e[32]);
        end
      end
    end
    prev_stall = drain_if.out_valid && !drain_if.out_ready;
    prev_data  = drain_if.out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; push11 = 1'b0; pushedge = 1'b0; push22 = 1'b0; seq_done = 1'b0;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    drain_if.out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_out_valid", 32'(drain_if.out_valid), 0);
    check("rst_out_data", drain_if.out_data, 0);
    check("rst_out_last", 32'(drain_if.out_last), 0);
    check("rst_tile_count", tile_count, 0);
    check("rst_errs", {30'd0, overflow_err, seq_err}, 0);
    check("rst_all_done", 32'(all_done), 0);
    reset = 1'b0;
    tick();

    // Single tile, ready held high: first word appears the cycle after push22
    pulse_start();
    drain_if.out_ready = 1'b1;
    push_tile(5, -3, 7, 100, 1'b1);
    check("single_first_valid", 32'(drain_if.out_valid), 1);
    check("single_first_data", drain_if.out_data, 5);
    tick(); tick(); tick(); tick(); tick();
    check("single_tile_count", tile_count, 1);
    check("single_drained", 32'(exp_q.size()), 0);

    // Backpressure with alternating ready
    pulse_start();
    drain_if.out_ready = 1'b0;
    push_tile(10, 11, -12, 13, 1'b1);
    push_tile(20, -21, 22, 23, 1'b1);
    check("bp_tile_count", tile_count, 2);
    drain_all(1'b1, 40);

    // Overflow: fifth tile dropped
    pulse_start();
    for (int t = 1; t <= 5; t++)
      push_tile(t*100+1, t*100+2, t*100+3, t*100+4, t <= 4);
    check("ovf_err", 32'(overflow_err), 1);
    check("ovf_tile_count", tile_count, 4);

    // Full FIFO with commit coinciding with the index-3 pop
    pulse_start();
    check("ovf_cleared", 32'(overflow_err), 0);
    drain_if.out_ready = 1'b1;
    tick();
    push_tile(601, 602, 603, 604, 1'b1);
    drain_if.out_ready = 1'b0;
    check("fullpop_no_ovf", 32'(overflow_err), 0);
    check("fullpop_count", tile_count, 1);
    drain_all(1'b0, 60);

    // Sequence errors: stray pushedge, then push11 restart inside a tile
    pulse_start();
    pushedge = 1'b1; c12 = 99; c21 = 98;
    tick();
    pushedge = 1'b0;
    check("seq_err_stray_edge", 32'(seq_err), 1);
    push11 = 1'b1; c11 = 9;
    tick();
    push11 = 1'b0;
    push_tile(1, 2, 3, 4, 1'b1);
    check("seq_err_sticky", 32'(seq_err), 1);
    check("seq_tile_count", tile_count, 1);
    drain_all(1'b0, 20);

    // Simultaneous push pulses
    pulse_start();
    check("start_clears_seq_err", 32'(seq_err), 0);
    push11 = 1'b1; push22 = 1'b1;
    tick();
    push11 = 1'b0; push22 = 1'b0;
    check("multi_push_seq_err", 32'(seq_err), 1);
    check("multi_push_no_commit", tile_count, 0);

    // Done: all_done the cycle after the 8th handshake
    pulse_start();
    push_tile(31, 32, 33, 34, 1'b1);
    push_tile(41, 42, 43, 44, 1'b1);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    check("done_wait_queued", 32'(all_done), 0);
    drain_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("done_early", 32'(all_done), 0);
      tick();
    end
    check("done_pulse", 32'(all_done), 1);
    drain_if.out_ready = 1'b0;
    tick();
    check("done_one_cycle", 32'(all_done), 0);
    check("done_drained", 32'(exp_q.size()), 0);

    // Reset mid-drain
    pulse_start();
    push_tile(51, 52, 53, 54, 1'b1);
    push_tile(61, 62, 63, 64, 1'b1);
    drain_if.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drain_if.out_ready = 1'b0;
    exp_q.delete();
    check("rst_mid_valid", 32'(drain_if.out_valid), 0);
    check("rst_mid_count", tile_count, 0);
    tick(); tick();
    check("rst_mid_stays_empty", 32'(drain_if.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_result_drain.md
# tile_result_drain

Downstream stage of the 2x2 tensor-core feed sequencer. It captures the four 32-bit signed accumulator results of each 2x2 output tile when the sequencer's push11 / pushedge / push22 pulses fire. Each completed tile is stored whole in a tile-wide FIFO. The FIFO drains as a ready/valid word stream, in the order c11, c12, c21, c22, toward the Croc bus-side result writer.

## Interface
Parameters:
- TILE_DEPTH, 4: FIFO capacity in whole tiles (power of two, ≥2).
- ACC_W, 32: accumulator and output word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  same pulse that starts the sequencer; clears tile_count, err flags, done_pending.
- push11  in  1  pulse; c11 is final this cycle.
- pushedge  in  1  pulse; c12 and c21 are final this cycle.
- push22  in  1  pulse; c22 is final this cycle; commits the tile.
- seq_done  in  1  sequencer valid pulse (whole operation finished).
- c11, c12, c21, c22  in  ACC_W each  signed array accumulators.
- out_data  out  ACC_W  current result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_last  out  1  high with the c22 word of each tile.
- tile_count  out  32  tiles committed to the FIFO since start.
- overflow_err  out  1  sticky: a tile was dropped because the FIFO was full.
- seq_err  out  1  sticky: a push pulse arrived out of order.
- all_done  out  1  one-cycle pulse: operation finished and fully drained.

## Operation
- Collect FSM states:
  - WAIT11 → WAITEDGE on push11: latch c11.
  - WAITEDGE → WAIT22 on pushedge: latch c12 and c21.
  - WAIT22 → WAIT11 on push22: commit {c11_q, c12_q, c21_q, c22} as one FIFO entry.
- Out-of-order pulses:
  - Any push not expected in the current state sets seq_err.
  - FSM returns to WAIT11, and no commit occurs.
  - Exception: push11 in WAITEDGE or WAIT22 is also treated as a fresh push11. It latches c11, sets seq_err, and the FSM moves to WAITEDGE.
  - More than one push bit high in the same cycle sets seq_err and returns the FSM to WAIT11.
- Commit rules:
  - If the FIFO is full at commit, the tile is dropped, overflow_err is set, and tile_count does not increment.
  - Otherwise the tile is written and tile_count increments, wrapping at 2^32.
  - A commit and a pop in the same cycle are both honoured. Count is unchanged, and a full FIFO accepts the commit.
- Output serializer:
  - out_valid = FIFO not empty.
  - A 2-bit word index selects c11, c12, c21, c22 of the head entry.
  - Each handshake increments the index. The handshake at index 3 pops the entry and resets the index to 0.
  - out_last = out_valid && index==3.
  - out_data is held stable while out_valid && !out_ready.
- seq_done sets done_pending. all_done pulses for one cycle when done_pending, FIFO empty, and FSM in WAIT11 all hold; done_pending then clears.
- start clears:
  - tile_count, overflow_err, seq_err, done_pending.
  - The collect FSM, which returns to WAIT11.
  - It does not flush the FIFO, so prior results still drain.
- Reset:
  - FSM → WAIT11; FIFO empty; index 0.
  - All outputs 0: out_data, out_valid, out_last, tile_count, both err flags, all_done.

## Timing
- Latches happen at the edge that ends the pulse cycle.
- Commit at the edge ending the push22 cycle; out_valid rises the next cycle (1-cycle latency).
- Throughput: 1 word/cycle with out_ready tied high, i.e. 4 cycles/tile.
- out_data comes from a combinational mux of registered FIFO storage; there is no output register.
- all_done is asserted no earlier than the cycle after the last pop.
- Reset mid-drain discards FIFO contents; out_valid is 0 the cycle after reset.

## Structure
- Shared package tensor_pkg holds:
  - ACC_W default.
  - typedef tile_t: packed struct of c11, c12, c21, c22, each logic signed [ACC_W-1:0].
  - typedef collect_state_t: WAIT11, WAITEDGE, WAIT22.
- Sub-module tile_fifo: synchronous FIFO of tile_t.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty.
  - Pointers one bit wider than log2(TILE_DEPTH) for wrap detection.
- Top level holds the collect FSM, serializer, counters and flags.

## Test plan
- Single tile, out_ready=1:
  - Stimulus: push11 with c11=5, pushedge with c12=-3 and c21=7, push22 with c22=100.
  - Response: out_data 5, -3, 7, 100 on consecutive cycles, starting the cycle after push22; out_last only on 100; tile_count=1.
- Backpressure:
  - Stimulus: two tiles committed, out_ready toggling 1,0,1,0.
  - Response: 8 words in order with no duplicates or drops; out_data stable while stalled.
- Overflow:
  - Stimulus: out_ready=0; commit 5 tiles with TILE_DEPTH=4.
  - Response: overflow_err=1 after the 5th push22; tile_count=4; draining returns only tiles 1–4.
- Full plus simultaneous pop:
  - Stimulus: FIFO full; push22 in the same cycle as the index-3 handshake.
  - Response: tile accepted, no overflow_err, count stays 4.
- Sequence error:
  - Stimulus: pushedge while in WAIT11, then a valid triple with values 1,2,3,4.
  - Response: seq_err=1; only tile {1,2,3,4} is emitted.
- Done and reset:
  - Stimulus: seq_done while 2 tiles are queued.
  - Response: all_done pulses once, the cycle after the 8th handshake.
  - Follow-up: reset mid-drain → out_valid=0, tile_count=0 next cycle.
